// File: rtl/fphub_sqrt_arbiter.sv
// fphub_sqrt_arbiter
//   Shares one FPHUB sqrt core among NREQ requesters. Requesters are picked
//   round-robin. The arbiter drives the core's start/finish handshake, captures
//   the result and the special-case flag, and returns them to the granted
//   requester over a valid/ready response channel. Only one operation is in
//   flight at any time.
//
// Ports
//   clk, rst_l          clock; asynchronous active-low reset (also resets the core)
//   req_valid/req_ready per-requester request; req_ready is a one-hot accept strobe
//   req_x               packed operands, requester i at [i*(M+E+1) +: M+E+1]
//   resp_valid/ready    one-hot response valid to the owner; per-requester accept
//   resp_res/special    shared result word and special-case flag
//   resp_err            watchdog timeout flag (always 0 unless the watchdog is built)
//   sq_*                interface to the single sqrt core instance
//
// Optional build macro: FPHUB_SQRT_ARB_TIMEOUT_EN adds a watchdog in WAIT. If the
//   core does not finish within TIMEOUT cycles, the arbiter responds with an
//   all-ones result, special=1 and err=1.
module fphub_sqrt_arbiter #(
  parameter int M       = 23,
  parameter int E       = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*(M+E+1)-1:0]   req_x,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           resp_valid,
  input  logic [NREQ-1:0]           resp_ready,
  output logic [M+E:0]              resp_res,
  output logic                      resp_special,
  output logic                      resp_err,
  output logic                      sq_start,
  output logic [M+E:0]              sq_x,
  input  logic [M+E:0]              sq_res,
  input  logic                      sq_finish,
  input  logic                      sq_computing,
  input  logic                      sq_special
);

  localparam int          W  = M + E + 1;
  localparam int          PW = $clog2(NREQ);
  localparam int unsigned NR = NREQ;

  if (NREQ < 2 || NREQ > 16 || TIMEOUT < 1) begin : g_param_check
    $error("fphub_sqrt_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   grant_q;
  logic [W-1:0]    x_q;
  logic [W-1:0]    res_q;
  logic            special_q;
  logic [PW-1:0]   sel;
  logic            found;
  int unsigned     idx;

`ifdef FPHUB_SQRT_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0]   wd_cnt;
  logic            err_q;
`endif

  // First requesting index at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = (32'(rr_ptr) + k) % NR;
      if (!found && req_valid[idx[PW-1:0]]) begin
        found = 1'b1;
        sel   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (state == IDLE && found) req_ready[sel] = 1'b1;
    if (state == RESP)          resp_valid[grant_q] = 1'b1;
  end

  assign sq_start     = (state == ISSUE) && !sq_computing;
  assign sq_x         = (state == ISSUE || state == WAIT) ? x_q : '0;
  assign resp_res     = (state == RESP) ? res_q : '0;
  assign resp_special = (state == RESP) && special_q;
`ifdef FPHUB_SQRT_ARB_TIMEOUT_EN
  assign resp_err     = (state == RESP) && err_q;
`else
  assign resp_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_q   <= '0;
      x_q       <= '0;
      res_q     <= '0;
      special_q <= 1'b0;
`ifdef FPHUB_SQRT_ARB_TIMEOUT_EN
      wd_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            x_q     <= req_x[32'(sel)*W +: W];
            grant_q <= sel;
            rr_ptr  <= (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (!sq_computing) begin
            state  <= WAIT;
`ifdef FPHUB_SQRT_ARB_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
        end
        WAIT: begin
          if (sq_finish) begin
            res_q     <= sq_res;
            special_q <= sq_special;
            state     <= RESP;
          end
`ifdef FPHUB_SQRT_ARB_TIMEOUT_EN
          // Last allowed WAIT cycle: give up on the core. A later
          // sq_finish lands outside WAIT and is ignored.
          else if (wd_cnt == CW'(TIMEOUT - 1)) begin
            res_q     <= '1;
            special_q <= 1'b1;
            err_q     <= 1'b1;
            state     <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (resp_ready[grant_q]) begin
`ifdef FPHUB_SQRT_ARB_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fphub_sqrt_arbiter.sv
// Bench for fphub_sqrt_arbiter: a behavioural sqrt core plus scoreboarded
// requesters. Expected results are pushed when a grant is seen and popped
// when the response handshake is seen.
module tb_fphub_sqrt_arbiter;

  localparam int M = 23, E = 8, NREQ = 4, W = 32, TO = 16;

  logic             clk = 1'b0;
  logic             rst_l;
  logic [NREQ-1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [NREQ*W-1:0] req_x;
  logic [W-1:0]     resp_res, sq_x, sq_res;
  logic             resp_special, resp_err, sq_start, sq_finish, sq_computing, sq_special;

  always #5 clk = ~clk;

  fphub_sqrt_arbiter #(.M(M), .E(E), .NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_res(resp_res), .resp_special(resp_special), .resp_err(resp_err),
    .sq_start(sq_start), .sq_x(sq_x), .sq_res(sq_res),
    .sq_finish(sq_finish), .sq_computing(sq_computing), .sq_special(sq_special)
  );

  typedef struct {
    int unsigned idx;
    logic [31:0] res;
    logic        sp;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int unsigned grant_log[$];
  int unsigned n_chk = 0, n_pass = 0;
  int unsigned starts = 0, cyc = 0, start_cyc = 0, last_lat = 0;
  logic [3:0]  acc_mask = '0;
  logic [31:0] last_x = '0;
  logic        prev_rv = 1'b0;
  logic        hold = 1'b0, force_busy = 1'b0, never_finish = 1'b0, expect_to = 1'b0;

  // Reference sqrt core behaviour: special cases return quickly.
  function automatic exp_t model(logic [31:0] x);
    exp_t e;
    e.idx = 0;
    e.err = 1'b0;
    if (x[30:0] == 31'd0)          begin e.res = x;     e.sp = 1'b1; end
    else if (x[31])                begin e.res = '1;    e.sp = 1'b1; end
    else if (x[30:23] == 8'hFF)    begin e.res = x;     e.sp = 1'b1; end
    else begin e.res = {1'b0, x[30:0]} ^ 32'h00A55A00;  e.sp = 1'b0; end
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Behavioural core
  logic        busy;
  int unsigned cd;
  logic [31:0] cx;
  assign sq_computing = busy | force_busy;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      busy <= 1'b0; cd <= 0; cx <= '0;
      sq_finish <= 1'b0; sq_res <= '0; sq_special <= 1'b0;
    end else begin
      sq_finish <= 1'b0;
      if (sq_start && !never_finish) begin
        busy <= 1'b1;
        cx   <= sq_x;
        cd   <= model(sq_x).sp ? 2 : M + 1;
      end else if (busy) begin
        if (cd == 2) begin
          sq_finish  <= 1'b1;
          sq_res     <= model(cx).res;
          sq_special <= model(cx).sp;
        end
        if (cd == 1) busy <= 1'b0;
        cd <= cd - 1;
      end
    end
  end

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin : mon
    exp_t        e;
    int unsigned g;
    logic [31:0] x;
    cyc++;
    if (rst_l) begin
      if (req_ready != '0) begin
        chk("grant_onehot", 64'($countones(req_ready)), 64'd1);
        g = 0;
        for (int unsigned i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        x = req_x[g*W +: W];
        e = model(x);
        e.idx = g;
        if (expect_to) begin e.res = '1; e.sp = 1'b1; e.err = 1'b1; end
        sb.push_back(e);
        grant_log.push_back(g);
        acc_mask = acc_mask | req_ready;
        last_x = x;
      end
      if (sq_start) begin
        starts++;
        start_cyc = cyc;
        chk("sq_x", 64'(sq_x), 64'(last_x));
      end
      if (resp_valid != '0 && !prev_rv) last_lat = cyc - start_cyc;
      if ((resp_valid & resp_ready) != '0) begin
        if (sb.size() == 0) chk("sb_underflow", 64'(resp_valid), 64'd0);
        else begin
          e = sb.pop_front();
          chk("resp_valid",   64'(resp_valid),   64'd1 << e.idx);
          chk("resp_res",     64'(resp_res),     64'(e.res));
          chk("resp_special", 64'(resp_special), 64'(e.sp));
          chk("resp_err",     64'(resp_err),     64'(e.err));
        end
      end
      prev_rv = |resp_valid;
    end
  end

  // Advance one cycle; retire requests accepted on that edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (!hold) req_valid = req_valid & ~acc_mask;
    acc_mask = '0;
  endtask

  task automatic issue(int unsigned i, logic [31:0] x);
    req_x[i*W +: W] = x;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_idle(string tag);
    int unsigned n = 0;
    while ((req_valid != '0 || sb.size() != 0) && n < 400) begin step(); n++; end
    chk({"idle_", tag}, {60'(sb.size()), req_valid}, 64'd0);
  endtask

  task automatic wait_grant(int unsigned target);
    int unsigned n = 0;
    while (grant_log.size() < target && n < 300) begin step(); n++; end
    chk("grant_wait", 64'(grant_log.size() >= target), 64'd1);
  endtask

  task automatic chk_outputs_zero(string tag);
    chk({tag, "_req_ready"},  64'(req_ready),    64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid),   64'd0);
    chk({tag, "_resp_res"},   64'(resp_res),     64'd0);
    chk({tag, "_resp_sp"},    64'(resp_special), 64'd0);
    chk({tag, "_resp_err"},   64'(resp_err),     64'd0);
    chk({tag, "_sq_start"},   64'(sq_start),     64'd0);
    chk({tag, "_sq_x"},       64'(sq_x),         64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned s0;
    int unsigned order[5];
    int unsigned n;
    order = '{0, 1, 2, 3, 0};
    rst_l = 1'b0; req_valid = '0; req_x = '0; resp_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_l = 1'b1;
    step();

    // Round robin with every requester asserted continuously.
    hold = 1'b1;
    for (int unsigned i = 0; i < NREQ; i++) issue(i, 32'h4080_0000 | (i << 4));
    wait_grant(5);
    req_valid = '0;
    hold = 1'b0;
    wait_idle("rr");
    for (int unsigned i = 0; i < 5; i++) chk("rr_order", 64'(grant_log[i]), 64'(order[i]));

    // Special-case operands on single requesters.
    s0 = starts;
    issue(0, 32'hBF80_0000); wait_idle("neg");
    chk("one_start", 64'(starts), 64'(s0 + 1));
    issue(2, 32'h0000_0000); wait_idle("zero");
    issue(1, 32'h7FFF_FFFF); wait_idle("nan");

    // Response held off; a non-owner's resp_ready must not complete it.
    resp_ready = 4'b0111;
    issue(3, 32'h3F80_0000);
    n = 0;
    while (resp_valid == '0 && n < 100) begin step(); n++; end
    issue(0, 32'h4110_0000);
    for (int unsigned i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", 64'(resp_valid), 64'h8);
      chk("hold_res",   64'(resp_res),   64'(model(32'h3F80_0000).res));
      chk("hold_ready", 64'(req_ready),  64'd0);
    end
    resp_ready = '1;
    step();
    chk("turnaround", 64'(req_ready), 64'h1);
    wait_idle("hold");

    // Core busy while ISSUE: start must wait, then pulse once.
    force_busy = 1'b1;
    n = grant_log.size();
    issue(1, 32'h4120_0000);
    wait_grant(n + 1);
    s0 = starts;
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      chk("busy_no_start", 64'(sq_start), 64'd0);
    end
    force_busy = 1'b0;
    wait_idle("busy");
    chk("busy_one_start", 64'(starts), 64'(s0 + 1));

    // Reset while WAIT (rr_ptr is 2 here): afterwards requester 0 wins over 3.
    s0 = starts;
    issue(2, 32'h40A0_0000);
    n = 0;
    while (starts == s0 && n < 50) begin step(); n++; end
    repeat (3) step();
    rst_l = 1'b0;
    req_valid = '0;
    #1;
    chk_outputs_zero("midreset");
    sb.delete(); grant_log.delete(); acc_mask = '0;
    repeat (2) step();
    rst_l = 1'b1;
    issue(3, 32'h4130_0000);
    issue(0, 32'h4140_0000);
    wait_grant(1);
    chk("post_reset_grant", 64'(grant_log[0]), 64'd0);
    wait_idle("post_reset");

`ifdef FPHUB_SQRT_ARB_TIMEOUT_EN
    never_finish = 1'b1;
    expect_to = 1'b1;
    n = grant_log.size();
    issue(3, 32'h4150_0000);
    wait_grant(n + 1);
    expect_to = 1'b0;
    wait_idle("timeout");
    chk("timeout_latency", 64'(last_lat), 64'(TO + 1));
    never_finish = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
